// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: decode/execute boundary register with a valid/ready
// handshake on both sides, a two-entry skid (main + skid), synchronous
// flush for branch redirect, and op-class decode applied at capture time.
module id_ex_skid_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int OP_HI_W = 3,
    parameter int OP_LO_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       id_valid,
    output logic                       id_ready,
    input  logic [OP_HI_W+OP_LO_W-1:0] id_exop,
    input  logic [DATA_W-1:0]          id_srcLeft,
    input  logic [DATA_W-1:0]          id_srcRight,
    input  logic [DATA_W-1:0]          id_offset,
    input  logic [REG_AW-1:0]          id_dest,
    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [2:0]                 ex_alusel,
    output logic [OP_LO_W-1:0]         ex_aluop,
    output logic [DATA_W-1:0]          ex_srcLeft,
    output logic [DATA_W-1:0]          ex_srcRight,
    output logic [DATA_W-1:0]          ex_offset,
    output logic [1:0]                 ex_memop,
    output logic [REG_AW-1:0]          ex_dest,
    output logic                       ex_writeEnable
);

    // Handshake: a transfer happens on a side exactly in a cycle where its
    // valid and ready are both high at the rising edge of clk. id_ready is
    // registered and never depends combinationally on ex_ready; ex_valid and
    // the ex_* payload come straight from the main entry register.

    localparam int EXOP_W = OP_HI_W + OP_LO_W;

    typedef struct packed {
        logic [2:0]         alusel;
        logic [OP_LO_W-1:0] aluop;
        logic [DATA_W-1:0]  src_left;
        logic [DATA_W-1:0]  src_right;
        logic [DATA_W-1:0]  offset;
        logic [1:0]         memop;
        logic [REG_AW-1:0]  dest;
        logic               we;
    } entry_t;

    // ST_ONE: main holds an entry; ST_TWO: main and skid both hold entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    entry_t              main_q;
    entry_t              skid_q;
    entry_t              in_entry;
    logic                id_ready_q;
    logic                in_xfer;
    logic                out_xfer;
    logic [OP_HI_W-1:0]  op_class;

    assign in_xfer  = id_valid & id_ready_q;
    assign out_xfer = (state != ST_EMPTY) & ex_ready;
    assign id_ready = id_ready_q;
    assign op_class = id_exop[EXOP_W-1 -: OP_HI_W];

    // Decode the incoming instruction into the control fields stored with it.
    always_comb begin
        in_entry           = '0;
        in_entry.aluop     = id_exop[OP_LO_W-1:0];
        in_entry.src_left  = id_srcLeft;
        in_entry.src_right = id_srcRight;
        in_entry.offset    = id_offset;
        in_entry.dest      = id_dest;
        case (int'(op_class))
            1: begin in_entry.alusel = 3'd1; in_entry.memop = 2'd1; in_entry.we = 1'b1; end
            2: begin in_entry.alusel = 3'd2; in_entry.memop = 2'd1; in_entry.we = 1'b1; end
            3: begin in_entry.alusel = 3'd3; in_entry.memop = 2'd1; in_entry.we = 1'b1; end
            4: begin in_entry.alusel = 3'd4; in_entry.memop = 2'd1; in_entry.we = 1'b1; end
            5: begin in_entry.alusel = 3'd5; in_entry.memop = 2'd2; in_entry.we = 1'b1; end
            6: begin in_entry.alusel = 3'd5; in_entry.memop = 2'd3; in_entry.we = 1'b0; end
            default: begin in_entry.alusel = 3'd0; in_entry.memop = 2'd0; in_entry.we = 1'b0; end
        endcase
        // r0 is hard-wired zero: suppress any register write aimed at it.
        if (id_dest == '0) begin
            in_entry.we = 1'b0;
            if (in_entry.memop == 2'd1) begin
                in_entry.memop = 2'd0;
            end
        end
    end

    // State register plus the registered ready, which is high whenever the
    // skid entry will be empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            id_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            id_ready_q <= (state_next != ST_TWO);
        end
    end

    // Next-state logic; flush empties the stage regardless of transfers.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_xfer) state_next = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_next = ST_TWO;
                else if (!in_xfer && out_xfer) state_next = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
        end
    end

    // Entry registers: load main or skid, shift skid forward on drain, and
    // zero anything that becomes invalid so idle outputs read as 0.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: if (in_xfer) main_q <= in_entry;
                ST_ONE: begin
                    if (in_xfer && out_xfer) main_q <= in_entry;
                    else if (in_xfer)        skid_q <= in_entry;
                    else if (out_xfer)       main_q <= '0;
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    // Output logic: the main entry drives EX, gated to zero when invalid.
    always_comb begin
        ex_valid       = (state != ST_EMPTY);
        ex_alusel      = '0;
        ex_aluop       = '0;
        ex_srcLeft     = '0;
        ex_srcRight    = '0;
        ex_offset      = '0;
        ex_memop       = '0;
        ex_dest        = '0;
        ex_writeEnable = 1'b0;
        if (ex_valid) begin
            ex_alusel      = main_q.alusel;
            ex_aluop       = main_q.aluop;
            ex_srcLeft     = main_q.src_left;
            ex_srcRight    = main_q.src_right;
            ex_offset      = main_q.offset;
            ex_memop       = main_q.memop;
            ex_dest        = main_q.dest;
            ex_writeEnable = main_q.we;
        end
    end

endmodule
